// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter that multiplexes fetch and data
// accesses onto the single data RAM.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  typedef enum logic {
    GntIf  = 1'b0,
    GntMem = 1'b1
  } gnt_e;

  // Width of the latency and consecutive-grant counters (both limited to 1..15).
  localparam int unsigned CntWidth = 4;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] val,
                                                  input logic [CntWidth-1:0] lim);
    return (val >= lim) ? lim : val + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Arbitrates the single data RAM between the fetch port and the load/store port,
// sequencing each access through IDLE -> ACCESS (LATENCY cycles) -> DONE.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned MAX_CONSEC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_done,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  localparam logic [CntWidth-1:0] LatLast   = CntWidth'(LATENCY - 1);
  localparam logic [CntWidth-1:0] MaxConsec = CntWidth'(MAX_CONSEC);

  state_e                  state_q, state_d;
  gnt_e                    gnt_q, gnt_d;
  logic [CntWidth-1:0]     lat_q, lat_d;
  logic [CntWidth-1:0]     consec_q, consec_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;

  logic any_req;
  logic grant_mem;
  logic last_access;

  assign any_req     = if_req | mem_req;
  // Data wins ties until it has taken MaxConsec grants in a row against a waiting fetch.
  assign grant_mem   = mem_req & (~if_req | (consec_q != MaxConsec));
  assign last_access = (state_q == StAccess) && (lat_q == LatLast);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= GntIf;
      lat_q       <= '0;
      consec_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lat_q       <= lat_d;
      consec_q    <= consec_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: if (last_access) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Grant, request capture, counters and read-data capture.
  always_comb begin
    gnt_d       = gnt_q;
    lat_d       = lat_q;
    consec_d    = consec_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    if (state_q == StIdle && any_req) begin
      lat_d = '0;
      if (grant_mem) begin
        gnt_d    = GntMem;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        we_d     = mem_we;
        consec_d = if_req ? sat_inc(consec_q, MaxConsec) : '0;
      end else begin
        gnt_d    = GntIf;
        addr_d   = if_addr;
        wdata_d  = '0;
        we_d     = 1'b0;
        consec_d = '0;
      end
    end

    if (state_q == StAccess) begin
      lat_d = last_access ? '0 : lat_q + 1'b1;
      if (last_access) begin
        if (gnt_q == GntIf) begin
          if_rdata_d = ram_data_out;
        end else if (!we_q) begin
          mem_rdata_d = ram_data_out;
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    ram_address      = '0;
    ram_data_in      = '0;
    ram_write_enable = 1'b0;
    if_done          = 1'b0;
    mem_done         = 1'b0;
    busy             = (state_q != StIdle);

    unique case (state_q)
      StAccess: begin
        ram_address      = addr_q;
        ram_data_in      = wdata_q;
        // Single-cycle strobe at the start of the access window.
        ram_write_enable = we_q && (gnt_q == GntMem) && (lat_q == '0);
      end
      StDone: begin
        if_done  = (gnt_q == GntIf);
        mem_done = (gnt_q == GntMem);
      end
      default: ;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a transaction-level model predicts every
// output each cycle, and directed scenarios pin key timings with literals.
module tb_ram_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_done, mem_done, ram_write_enable, busy;
  logic [DW-1:0] if_rdata, mem_rdata, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_address;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LATENCY   (LAT),
    .MAX_CONSEC(MAXC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_done         (if_done),
    .if_rdata        (if_rdata),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_done        (mem_done),
    .mem_rdata       (mem_rdata),
    .ram_address     (ram_address),
    .ram_data_in     (ram_data_in),
    .ram_write_enable(ram_write_enable),
    .ram_data_out    (ram_data_out),
    .busy            (busy)
  );

  // Simple RAM: combinational read of the presented address, write on the clock edge.
  logic [DW-1:0] ram_mem [256];
  assign ram_data_out = ram_mem[ram_address[7:0]];
  always @(posedge clk) if (ram_write_enable) ram_mem[ram_address[7:0]] <= ram_data_in;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one record for the access in flight, started at cycle m_s.
  int            cyc = 0;
  bit            m_active = 1'b0;
  int            m_s = 0;
  bit            m_gnt_mem = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  bit            m_we = 1'b0;
  int            m_consec = 0;
  logic [DW-1:0] m_if_rd = '0;
  logic [DW-1:0] m_mem_rd = '0;
  logic [DW-1:0] m_mem [256];

  initial forever begin
    int off;
    @(posedge clk);
    off = cyc - m_s;
    if (m_active && off == 1 && m_we) m_mem[m_addr[7:0]] = m_wd;
    if (rst) begin
      m_active = 1'b0;
      m_consec = 0;
      m_if_rd  = '0;
      m_mem_rd = '0;
    end else if (m_active) begin
      if (off == LAT) begin
        if (!m_gnt_mem) m_if_rd = m_mem[m_addr[7:0]];
        else if (!m_we) m_mem_rd = m_mem[m_addr[7:0]];
      end
      if (off == LAT + 1) m_active = 1'b0;
    end else if (if_req || mem_req) begin
      m_gnt_mem = mem_req && !(if_req && m_consec == MAXC);
      if (m_gnt_mem) begin
        m_addr   = mem_addr;
        m_wd     = mem_wdata;
        m_we     = mem_we;
        m_consec = if_req ? ((m_consec < MAXC) ? m_consec + 1 : m_consec) : 0;
      end else begin
        m_addr   = if_addr;
        m_wd     = '0;
        m_we     = 1'b0;
        m_consec = 0;
      end
      m_s      = cyc;
      m_active = 1'b1;
    end
    cyc = cyc + 1;
  end

  initial forever begin
    int off;
    bit acc, dn;
    @(negedge clk);
    if (chk_en) begin
      off = cyc - m_s;
      acc = m_active && off >= 1 && off <= LAT;
      dn  = m_active && off == LAT + 1;
      check("busy", busy, m_active && off >= 1);
      check("if_done", if_done, dn && !m_gnt_mem);
      check("mem_done", mem_done, dn && m_gnt_mem);
      check("ram_address", ram_address, acc ? m_addr : '0);
      check("ram_data_in", ram_data_in, acc ? m_wd : '0);
      check("ram_write_enable", ram_write_enable, acc && off == 1 && m_we);
      check("if_rdata", if_rdata, m_if_rd);
      check("mem_rdata", mem_rdata, m_mem_rd);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Waits (bounded) until a done pulse is visible in the current cycle.
  task automatic wait_done();
    int c;
    c = 0;
    while (!(if_done || mem_done) && c < 12) begin
      tick(1);
      c++;
    end
    check("done_within_bound", (c < 12), 1);
  endtask

  initial begin
    logic [5:0] seq;
    int d0, d1;
    rst = 1'b1;
    if_req = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    if_addr = '0;
    mem_addr = '0;
    mem_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'h01010101 * i ^ 32'hA5A50000;
      m_mem[i]   = 32'h01010101 * i ^ 32'hA5A50000;
    end
    ram_mem[8'h10] = 32'hDEADBEEF;
    m_mem[8'h10]   = 32'hDEADBEEF;

    // Reset held for two cycles, then idle with no requests.
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_we", ram_write_enable, 0);
    check("rst_addr", ram_address, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);

    // Single fetch from 0x10.
    if_addr = 32'h10;
    if_req = 1'b1;
    tick(1);
    check("f_addr_c1", ram_address, 32'h10);
    check("f_done_c1", if_done, 0);
    tick(1);
    check("f_addr_c2", ram_address, 32'h10);
    check("f_done_c2", if_done, 0);
    tick(1);
    check("f_done_c3", if_done, 1);
    check("f_rdata_c3", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    tick(1);
    check("f_rdata_held", if_rdata, 32'hDEADBEEF);
    check("f_idle", busy, 0);

    // Single store to 0x20.
    mem_addr = 32'h20;
    mem_wdata = 32'h55;
    mem_we = 1'b1;
    mem_req = 1'b1;
    tick(1);
    check("s_we_c1", ram_write_enable, 1);
    check("s_din_c1", ram_data_in, 32'h55);
    tick(1);
    check("s_we_c2", ram_write_enable, 0);
    tick(1);
    check("s_done_c3", mem_done, 1);
    check("s_rdata_kept", mem_rdata, 0);
    mem_req = 1'b0;
    mem_we = 1'b0;
    tick(1);

    // Contention: both held high, expect D,D,I,D,D,I.
    if_addr = 32'h30;
    mem_addr = 32'h40;
    if_req = 1'b1;
    mem_req = 1'b1;
    seq = '0;
    for (int k = 0; k < 6; k++) begin
      wait_done();
      seq = {seq[4:0], mem_done};
      if (k == 5) begin
        if_req = 1'b0;
        mem_req = 1'b0;
      end
      tick(1);
    end
    check("grant_order", seq, 6'b110110);

    // Reset in the second ACCESS cycle of a store.
    mem_addr = 32'h50;
    mem_wdata = 32'h77;
    mem_we = 1'b1;
    mem_req = 1'b1;
    tick(2);
    rst = 1'b1;
    mem_req = 1'b0;
    mem_we = 1'b0;
    tick(1);
    rst = 1'b0;
    check("ra_busy", busy, 0);
    check("ra_done", mem_done, 0);
    check("ra_we", ram_write_enable, 0);
    check("ra_addr", ram_address, 0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("ra_no_done", mem_done, 0);
    end

    // The strobed store survives the reset.
    mem_addr = 32'h50;
    mem_req = 1'b1;
    tick(3);
    check("ra_load_done", mem_done, 1);
    check("ra_store_kept", mem_rdata, 32'h77);
    mem_req = 1'b0;
    tick(1);

    // Back-to-back: mem_req held through the first done.
    mem_addr = 32'h10;
    mem_req = 1'b1;
    d0 = -1;
    d1 = -1;
    for (int c = 0; c < 9; c++) begin
      if (mem_done) begin
        if (d0 < 0) d0 = c;
        else d1 = c;
      end
      if (c == 7) mem_req = 1'b0;
      tick(1);
    end
    check("b2b_first", d0, 3);
    check("b2b_second", d1, 7);
    check("b2b_rdata", mem_rdata, 32'hDEADBEEF);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data RAM between two requesters:
  - instruction-fetch port (read-only), driven by the fetch stage;
  - data port (load/store), driven by the memory stage.
- Sequences each access with a small FSM that covers fixed RAM read latency, one-cycle write strobes and completion pulses.
- Sits between the pipeline stages and the ram instance in cpu, replacing their direct connection.
- The fetch stage and memory stage stall until their respective done pulse.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- LATENCY, 1, cycles from address presented to ram_data_out valid; legal range 1..15.
- MAX_CONSEC, 2, maximum consecutive data-port grants while a fetch request is pending; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request; held high until if_done.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_done  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  DATA_WIDTH  fetch read data; valid from if_done and held until the next fetch completion.
- mem_req  in  1  data request; held high until mem_done.
- mem_we  in  1  1 = store, 0 = load; stable while mem_req is high.
- mem_addr  in  ADDR_WIDTH  data address.
- mem_wdata  in  DATA_WIDTH  store data.
- mem_done  out  1  one-cycle pulse: data access complete.
- mem_rdata  out  DATA_WIDTH  load data; held until the next load completion.
- ram_address  out  ADDR_WIDTH  to ram.address.
- ram_data_in  out  DATA_WIDTH  to ram.data_in.
- ram_write_enable  out  1  to ram.write_enable.
- ram_data_out  in  DATA_WIDTH  from ram.data_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset effects:
  - state goes to IDLE; the grant, consec and latency counters clear.
  - All outputs drive 0, including if_rdata and mem_rdata.
- States:
  - IDLE: samples requests.
  - ACCESS: drives the RAM for LATENCY cycles.
  - DONE: one cycle; pulses the granted port's done, then returns to IDLE.
- Grant in IDLE, registered on the edge leaving IDLE:
  - only one request high: grant that port.
  - both high: grant data, unless consec == MAX_CONSEC, in which case grant fetch.
  - neither high: stay in IDLE.
- consec counter:
  - increments on each data grant made while if_req is high;
  - clears on any fetch grant, and on any data grant made while if_req is low.
  - It saturates, never wraps.
- Request capture: address, we and wdata are captured into registers at grant. Later input changes do not affect the in-flight access.
- ACCESS outputs:
  - ram_address = captured address for all LATENCY cycles.
  - ram_data_in = captured wdata for all LATENCY cycles.
  - ram_write_enable = 1 only in the first ACCESS cycle, and only for a store; never otherwise.
- Read capture: in the last ACCESS cycle, ram_data_out is registered into the granted port's rdata (loads and fetches only). Stores leave mem_rdata unchanged.
- Done pulse: done asserts during DONE for exactly one cycle.
- Latency: request sampled in IDLE at cycle 0 → done high at cycle LATENCY+1.
- Throughput: one access per LATENCY+2 cycles.
- Outside ACCESS: ram_address, ram_data_in and ram_write_enable drive 0.
- Requester obligation: drop req in the cycle after done. If req is still high in the following IDLE cycle, it is a new request and is re-arbitrated.
- Reset during ACCESS or DONE:
  - in-flight access is aborted; no done pulse is issued;
  - ram_write_enable is low from the next cycle.
- A store already strobed before reset is not undone.
- Simultaneous new request and done: a request arriving while busy waits; no queueing beyond the two req lines.

Decomposition:
- Shared constants go in a cpu/ header of `define`s alongside the other cpu defines:
  - state encodings ST_IDLE, ST_ACCESS, ST_DONE;
  - grant IDs GNT_IF, GNT_MEM.
- No sub-module is needed: the FSM, latency counter, consec counter and capture registers live in one module.
- cpu connects ram_* to the ram instance and routes the done pulses into the stall logic of fetch and memory.

Test Plan:
- Reset: hold rst 2 cycles, then release with no requests → all outputs 0, busy 0, ram_write_enable never 1.
- Single fetch, LATENCY=2: if_req with if_addr=0x10; ram returns 0xDEADBEEF → ram_address=0x10 in cycles 1–2, if_done only at cycle 3, if_rdata=0xDEADBEEF held afterwards.
- Single store, LATENCY=2: mem_addr=0x20, mem_wdata=0x55 → ram_write_enable high in cycle 1 only, mem_done at cycle 3, mem_rdata unchanged.
- Contention, MAX_CONSEC=2: if_req and mem_req held high, each re-asserted after every done → grant order D,D,I,D,D,I; fetch never waits more than 2 data accesses.
- Reset mid-access: rst at cycle 2 of a store with LATENCY=3 → no mem_done, busy 0 and ram_* 0 from the next cycle, state IDLE.
- Back-to-back: mem_req held through mem_done, LATENCY=1 → second access starts in the following IDLE cycle, mem_done pulses at cycles 2 and 5.
